mult_div_unit: RTL and testbench

Multicycle integer multiply/divide unit for the multicycle MIPS core. It sits beside the ALU stage and is fed from the A/B operand registers. It produces the HI/LO pair that the write-back mux consumes for MFHI/MFLO. The control FSM issues one operation with `start`, then stalls on `busy` until `done` pulses.

---
 rtl/mult_div_unit.sv | 178 +++++++++++++++++
 tb/tb_mult_div_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Multicycle shift-add multiplier and restoring divider producing the HI/LO pair.
// Define MULTDIV_DIVIDE_EN to build the divider; without it DIV/DIVU complete as illegal.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             illegal,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);
  // state  | meaning
  // IDLE   | waiting for start; MTHI/MTLO writes accepted
  // RUN    | one multiply/divide iteration per cycle
  // FINISH | sign fix-up, commit HI/LO and flags, pulse done
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand;
  logic               neg_lo, fin_dz, fin_ill;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_res;

  assign a_neg = ~op[0] & A[WIDTH-1];
  assign b_neg = ~op[0] & B[WIDTH-1];
  assign a_mag = a_neg ? -A : A;
  assign b_mag = b_neg ? -B : B;

  // acc = {partial product, remaining multiplier bits}; add then shift right
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
  assign mul_res = neg_lo ? -acc : acc;

`ifdef MULTDIV_DIVIDE_EN
  logic [WIDTH-1:0] rem;
  logic             fin_div, neg_hi;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] quot, remd;

  // acc low half holds the dividend shifting out MSB first while quotient bits shift in
  assign div_shift = {rem, acc[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, mcand};
  assign div_diff  = div_shift[WIDTH-1:0] - mcand;
  assign quot      = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign remd      = neg_hi ? -rem : rem;
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge Clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef MULTDIV_DIVIDE_EN
          if (op[1] && (B == '0)) state_nxt = FINISH;
          else                    state_nxt = RUN;
`else
          if (op[1]) state_nxt = FINISH;
          else       state_nxt = RUN;
`endif
        end
      end
      RUN:     if (cnt == CW'(WIDTH-1)) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      neg_lo   <= 1'b0;
      fin_dz   <= 1'b0;
      fin_ill  <= 1'b0;
      HI       <= '0;
      LO       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      illegal  <= 1'b0;
`ifdef MULTDIV_DIVIDE_EN
      rem      <= '0;
      fin_div  <= 1'b0;
      neg_hi   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt    <= '0;
            neg_lo <= a_neg ^ b_neg;
`ifdef MULTDIV_DIVIDE_EN
            fin_dz  <= op[1] & (B == '0);
            fin_ill <= 1'b0;
            fin_div <= op[1];
            neg_hi  <= a_neg;
            rem     <= '0;
            if (op[1]) begin
              acc   <= {{WIDTH{1'b0}}, a_mag};
              mcand <= b_mag;
            end else begin
              acc   <= {{WIDTH{1'b0}}, b_mag};
              mcand <= a_mag;
            end
`else
            fin_dz  <= 1'b0;
            fin_ill <= op[1];
            acc     <= {{WIDTH{1'b0}}, b_mag};
            mcand   <= a_mag;
`endif
          end else begin
            if (hi_we) HI <= A;
            if (lo_we) LO <= A;
          end
        end
        RUN: begin
          cnt <= cnt + CW'(1);
`ifdef MULTDIV_DIVIDE_EN
          if (fin_div) begin
            rem             <= div_ge ? div_diff : div_shift[WIDTH-1:0];
            acc[WIDTH-1:0]  <= {acc[WIDTH-2:0], div_ge};
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end
`else
          acc <= {mul_sum, acc[WIDTH-1:1]};
`endif
        end
        FINISH: begin
          done     <= 1'b1;
          div_zero <= fin_dz;
          illegal  <= fin_ill;
`ifdef MULTDIV_DIVIDE_EN
          if (!fin_dz) begin
            if (fin_div) begin
              HI <= remd;
              LO <= quot;
            end else begin
              HI <= mul_res[2*WIDTH-1:WIDTH];
              LO <= mul_res[WIDTH-1:0];
            end
          end
`else
          if (!fin_ill) begin
            HI <= mul_res[2*WIDTH-1:WIDTH];
            LO <= mul_res[WIDTH-1:0];
          end
`endif
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected results, a negedge monitor checks them.
// Expectations follow MULTDIV_DIVIDE_EN the same way the design build does.
module tb_mult_div_unit;
  localparam int W = 32;

  logic         Clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         hi_we = 1'b0;
  logic         lo_we = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         busy, done, div_zero, illegal;
  logic [W-1:0] HI, LO;

  mult_div_unit #(.WIDTH(W)) dut (
    .Clk(Clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .hi_we(hi_we), .lo_we(lo_we), .busy(busy), .done(done),
    .div_zero(div_zero), .illegal(illegal), .HI(HI), .LO(LO)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    logic        ill;
    int          lat;
    int          k;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural operands.
  function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sa, sb;
    logic [63:0] r64;
    e.hi = hi_m; e.lo = lo_m; e.dz = 1'b0; e.ill = 1'b0; e.lat = W + 1; e.k = 0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: begin r64 = sa * sb; e.hi = r64[63:32]; e.lo = r64[31:0]; end
      2'b01: begin r64 = {32'b0, a} * {32'b0, b}; e.hi = r64[63:32]; e.lo = r64[31:0]; end
      default: begin
`ifdef MULTDIV_DIVIDE_EN
        if (b == 32'd0) begin
          e.dz = 1'b1; e.lat = 1;
        end else if (o == 2'b10) begin
          r64 = sa / sb; e.lo = r64[31:0];
          r64 = sa % sb; e.hi = r64[31:0];
        end else begin
          e.lo = a / b; e.hi = a % b;
        end
`else
        e.ill = 1'b1; e.lat = 1;
`endif
      end
    endcase
    return e;
  endfunction

  always @(negedge Clk) begin
    exp_t e;
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("HI", 64'(HI), 64'(e.hi));
        chk("LO", 64'(LO), 64'(e.lo));
        chk("div_zero", 64'(div_zero), 64'(e.dz));
        chk("illegal", 64'(illegal), 64'(e.ill));
        chk("latency", 64'(cyc - e.k), 64'(e.lat));
        chk("busy_at_done", 64'(busy), 64'd0);
      end
    end
  end

  // Called at a negedge; returns at the negedge where busy has dropped (the done cycle).
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit we_too, input bit disturb);
    exp_t e;
    int   n;
    e = model(o, a, b);
    e.k = cyc + 1;
    exp_q.push_back(e);
    hi_m = e.hi; lo_m = e.lo;
    start = 1'b1; op = o; A = a; B = b; hi_we = we_too; lo_we = we_too;
    @(negedge Clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'($urandom); A = $urandom; B = $urandom;
    chk("busy_after_start", 64'(busy), 64'd1);
    n = 0;
    while (busy && n < 40) begin
      if (disturb && n == 3) begin
        start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; op = 2'($urandom); A = $urandom;
      end else begin
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      end
      @(negedge Clk);
      n++;
    end
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    if (n >= 40) begin
      n_chk++; n_fail++;
      $display("FAIL busy_timeout: got busy=1 after %0d cycles expected release", n);
    end
  endtask

  task automatic mt(input bit h, input bit l, input logic [31:0] v);
    hi_we = h; lo_we = l; A = v;
    @(negedge Clk);
    hi_we = 1'b0; lo_we = 1'b0; A = $urandom;
    if (h) hi_m = v;
    if (l) lo_m = v;
    chk("HI_after_mt", 64'(HI), 64'(hi_m));
    chk("LO_after_mt", 64'(LO), 64'(lo_m));
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected completion within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge Clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_div_zero", 64'(div_zero), 64'd0);
    chk("rst_illegal", 64'(illegal), 64'd0);
    chk("rst_HI", 64'(HI), 64'd0);
    chk("rst_LO", 64'(LO), 64'd0);
    reset = 1'b0;
    @(negedge Clk);

    issue(2'b00, 32'd7, 32'hFFFF_FFFD, 1'b0, 1'b0);
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    mt(1'b1, 1'b0, 32'h11);
    mt(1'b0, 1'b1, 32'h22);
    issue(2'b11, 32'd7, 32'd0, 1'b1, 1'b0);
    issue(2'b00, 32'h1234_5678, 32'h8765_4321, 1'b0, 1'b1);
    issue(2'b11, 32'd100, 32'd7, 1'b0, 1'b0);

    // reset in the middle of a multiply: abort, clear, and no done afterwards
    start = 1'b1; op = 2'b00; A = $urandom; B = $urandom;
    @(negedge Clk);
    start = 1'b0;
    repeat (9) @(negedge Clk);
    reset = 1'b1;
    @(negedge Clk);
    reset = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_HI", 64'(HI), 64'd0);
    chk("abort_LO", 64'(LO), 64'd0);
    chk("abort_div_zero", 64'(div_zero), 64'd0);
    chk("abort_illegal", 64'(illegal), 64'd0);
    hi_m = '0; lo_m = '0;
    repeat (40) @(negedge Clk);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0)
        mt(1'($urandom), 1'($urandom), $urandom);
      issue(2'($urandom), rnd_opnd(), rnd_opnd(), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 5) == 0) && 1'b0);
    end
    for (int i = 0; i < 6; i++)
      issue(2'($urandom_range(0, 1)), $urandom, $urandom, 1'b0, 1'b1);

    repeat (5) @(negedge Clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
